mode_sequencer: RTL and testbench
=================================

# mode_sequencer

Debounced, handshaked mode controller for the board's 2-bit mode select. It turns the raw next/prev push-buttons into clean single mode-change events and skips modes disabled by a mask. Before each change it asks the mode-dependent datapath to quiesce, then commits the new mode with a one-cycle load strobe. It sits between the button pins and every block that consumes mode_select.

## Interface
- DEBOUNCE_CYCLES, 1000000: number of stable synchronized samples before a button level is accepted (10 ms at 100 MHz); minimum 2.
- ACK_TIMEOUT, 1023: maximum cycles spent waiting for each quiesce_ack edge before the change is aborted.
- MODE_MASK, 4'b1111: bit i = 1 enables mode i. Bit 0 must be 1.

- clk_100Mhz  input  1  system clock, all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- btn_next  input  1  raw asynchronous button; a press advances the mode.
- btn_prev  input  1  raw asynchronous button; a press steps the mode back.
- quiesce_ack  input  1  datapath level acknowledge that it is idle.
- mode_select  output  2  current committed mode.
- quiesce_req  output  1  level request to the datapath to go idle.
- mode_load  output  1  one-cycle strobe in the cycle mode_select takes its new value.
- busy  output  1  high whenever the FSM is not in IDLE.
- timeout_err  output  1  sticky flag, set on any aborted change; cleared only by reset.

## Operation
- Reset, sampled on clk_100Mhz with reset_in = 1, forces the following values:
  - mode_select = 0; quiesce_req, mode_load, busy and timeout_err = 0.
  - FSM returns to IDLE.
  - Synchronizers, debounced levels and debounce counters are all cleared.
- Per button, the input conditioning is:
  - A 2-flop synchronizer feeds a debounce counter.
  - The counter clears whenever the synchronized value equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - A 0->1 transition of the debounced level is a press event, exactly one cycle wide.
- Event acceptance happens only in IDLE:
  - next-only: target = next enabled mode above the current one, wrapping 3 -> 0.
  - prev-only: target = next enabled mode below the current one, wrapping 0 -> 3.
  - Both events in the same cycle: both are ignored.
  - If target == mode_select (only one mode enabled), the event is dropped and no handshake occurs.
  - Events arriving outside IDLE are dropped, never queued.
- FSM states:
  - IDLE: on an accepted event, latch the target, clear the timeout counter and go to REQ.
  - REQ: quiesce_req = 1. On quiesce_ack = 1 go to LOAD. If the timeout counter reaches ACK_TIMEOUT first, set timeout_err and go to RELEASE without changing the mode.
  - LOAD: one cycle. mode_select <= target, mode_load = 1. Clear the timeout counter and go to RELEASE.
  - RELEASE: quiesce_req = 0. On quiesce_ack = 0 go to IDLE. On timeout, set timeout_err and go to IDLE.
- busy = (state != IDLE).
- mode_select changes only on the LOAD cycle.
- Timeout counters are sized as clog2(ACK_TIMEOUT+1) bits and never wrap.
- Reset asserted in any state wins: the FSM returns to IDLE and any mode change still in flight is lost.

## Timing
- All outputs are registered.
- Button edge to press event: 2 synchronizer cycles plus DEBOUNCE_CYCLES cycles.
- Event in cycle E: busy = 1 and quiesce_req = 1 from cycle E+1.
- quiesce_ack first sampled high in cycle A:
  - mode_load = 1 and the new mode_select are visible in cycle A+1.
  - quiesce_req = 0 from cycle A+2.
- Abort: timeout_err rises ACK_TIMEOUT+1 cycles after quiesce_req rises, if ack never arrives.
- Back-to-back changes: minimum spacing is 4 cycles plus the debounce time, since a new event is accepted only in IDLE.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and ACK_TIMEOUT = 8.

1. Reset, then btn_next held high 10 cycles, with ack following req after 2 cycles:
   - exactly one mode_load pulse;
   - mode_select goes 0 -> 1;
   - busy returns to 0.
2. btn_next glitching high 2 cycles out of every 3 -> no press event, no quiesce_req.
3. Four clean next presses with MODE_MASK = 4'b1011 -> mode_select sequence 1, 3, 0, 1 (mode 2 skipped).
4. prev press from mode 0 with MODE_MASK = 4'b1111 -> mode_select = 3, with mode_load high in the cycle after ack.
5. quiesce_ack tied 0, then a next press:
   - quiesce_req high for 9 cycles, then drops;
   - timeout_err = 1 and stays 1 through later successful changes;
   - mode_select unchanged.
6. Mid-handshake disturbances:
   - next and prev debounced edges in the same cycle -> no change.
   - A second press during REQ is dropped.
   - reset_in pulsed during REQ -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/mode_sequencer.sv
// Debounced next/prev mode controller with a quiesce handshake around each
// mode commit. Disabled modes (MODE_MASK) are skipped when stepping.
module mode_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // One-cycle pulse on the rising edge of the accepted level.
  assign press = level & ~level_d;
endmodule

module mode_sequencer #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         ACK_TIMEOUT     = 1023,
  parameter logic [3:0] MODE_MASK       = 4'b1111
) (
  input  logic       clk_100Mhz,
  input  logic       reset_in,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       quiesce_ack,
  output logic [1:0] mode_select,
  output logic       quiesce_req,
  output logic       mode_load,
  output logic       busy,
  output logic       timeout_err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, RELEASE} state_t;

  state_t        state;
  logic [1:0]    target;
  logic [TW-1:0] tcnt;
  logic [1:0]    btn;
  logic [1:0]    press;
  logic          ev_next;
  logic          ev_prev;
  logic [1:0]    step_tgt;
  logic          accept;
  logic          tmo;

  assign btn = {btn_prev, btn_next};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_deb
      mode_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk_100Mhz),
        .rst   (reset_in),
        .raw   (btn[g]),
        .press (press[g])
      );
    end
  endgenerate

  // Nearest enabled mode in the chosen direction; the smallest distance wins.
  function automatic logic [1:0] step(input logic [1:0] cur, input logic up);
    logic [1:0] m;
    step = cur;
    for (int k = 3; k >= 1; k--) begin
      m = up ? cur + 2'(k) : cur - 2'(k);
      if (MODE_MASK[m]) step = m;
    end
  endfunction

  always_comb begin
    ev_next  = press[0] & ~press[1];
    ev_prev  = press[1] & ~press[0];
    step_tgt = step(mode_select, ev_next);
    accept   = (ev_next | ev_prev) && (step_tgt != mode_select);
    tmo      = (tcnt == TW'(ACK_TIMEOUT));
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset_in) begin
      state       <= IDLE;
      target      <= '0;
      tcnt        <= '0;
      mode_select <= '0;
      quiesce_req <= 1'b0;
      mode_load   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mode_load <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target      <= step_tgt;
            tcnt        <= '0;
            state       <= REQ;
            quiesce_req <= 1'b1;
            busy        <= 1'b1;
          end
        end
        REQ: begin
          if (quiesce_ack) begin
            state       <= LOAD;
            mode_select <= target;
            mode_load   <= 1'b1;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            quiesce_req <= 1'b0;
            tcnt        <= '0;
            state       <= RELEASE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        LOAD: begin
          quiesce_req <= 1'b0;
          tcnt        <= '0;
          state       <= RELEASE;
        end
        RELEASE: begin
          if (!quiesce_ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          quiesce_req <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mode_sequencer.sv
// Random and directed stimulus for mode_sequencer; expected commits are
// queued by a list-based mode model and popped by a monitor on mode_load.
module tb_mode_sequencer;
  localparam logic [3:0] MASK = 4'b1011;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       quiesce_ack = 1'b0;
  logic [1:0] mode_select;
  logic       quiesce_req;
  logic       mode_load;
  logic       busy;
  logic       timeout_err;

  int   total = 0;
  int   bad = 0;
  int   exp_q[$];
  int   exp_mode = 0;
  int   loads = 0;
  bit   ack_en = 1'b1;
  int   dly = 2;
  logic [7:0] hist = '0;
  bit   req_any = 1'b0;
  int   run = 0;
  int   last_run = 0;
  logic ack_p = 1'b0;
  logic ack_p2 = 1'b0;

  always #5 clk = ~clk;

  mode_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .ACK_TIMEOUT     (8),
    .MODE_MASK       (MASK)
  ) dut (
    .clk_100Mhz  (clk),
    .reset_in    (reset_in),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .quiesce_ack (quiesce_ack),
    .mode_select (mode_select),
    .quiesce_req (quiesce_req),
    .mode_load   (mode_load),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Enabled modes as an ordered list; stepping is a circular index move.
  function automatic int model_step(input int cur, input bit up);
    int en[$];
    int idx;
    logic [3:0] mk;
    mk  = MASK;
    idx = 0;
    for (int m = 0; m < 4; m++) if (mk[m]) en.push_back(m);
    foreach (en[i]) if (en[i] == cur) idx = i;
    if (up) idx = (idx + 1) % en.size();
    else    idx = (idx + en.size() - 1) % en.size();
    return en[idx];
  endfunction

  // Datapath stand-in: ack follows req after dly cycles.
  initial forever begin
    @(posedge clk);
    #2;
    hist = {hist[6:0], quiesce_req};
    quiesce_ack = ack_en && hist[dly-1];
  end

  initial forever begin
    @(negedge clk);
    if (quiesce_req) begin
      req_any = 1'b1;
      run++;
    end else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    if (mode_load) begin
      loads++;
      check("load_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) check("load_mode", mode_select, exp_q.pop_front());
      check("load_after_ack_edge", {ack_p2, ack_p}, 2'b01);
    end
    ack_p2 = ack_p;
    ack_p  = quiesce_ack;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    exp_mode = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  // kind: 0 next, 1 prev, 2 both together
  task automatic press(input int kind, input int d);
    int t;
    dly = d;
    if (kind != 2 && ack_en) begin
      t = model_step(exp_mode, kind == 0);
      if (t != exp_mode) begin
        exp_q.push_back(t);
        exp_mode = t;
      end
    end
    @(negedge clk);
    btn_next = (kind != 1);
    btn_prev = (kind != 0);
    cycles(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cycles(12);
    wait_idle("press");
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mode"}, mode_select, 0);
    check({name, "_req"}, quiesce_req, 0);
    check({name, "_load"}, mode_load, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_err"}, timeout_err, 0);
  endtask

  initial begin
    int loads0;
    int m0;
    int k;
    int n;
    int seq[4];
    seq = '{1, 3, 0, 1};

    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    reset_in = 1'b0;

    // single next press
    loads0 = loads;
    press(0, 2);
    check("t1_mode", mode_select, 1);
    check("t1_loads", loads - loads0, 1);

    // glitching button never settles
    req_any = 1'b0;
    loads0 = loads;
    for (int i = 0; i < 30; i++) begin
      btn_next = ((i % 3) != 2);
      @(negedge clk);
    end
    btn_next = 1'b0;
    cycles(12);
    check("t2_no_req", req_any, 0);
    check("t2_loads", loads - loads0, 0);
    check("t2_mode", mode_select, 1);

    // four next presses skip the disabled mode
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(0, 1 + i % 3);
      check("t3_seq", mode_select, seq[i]);
    end

    // prev from mode 0 wraps to 3
    do_reset();
    press(1, 2);
    check("t4_mode", mode_select, 3);

    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 4);
      press((k == 0) ? 2 : (k < 3) ? 1 : 0, $urandom_range(1, 3));
      check("rand_mode", mode_select, exp_mode);
    end

    // ack never arrives
    ack_en = 1'b0;
    m0 = exp_mode;
    press(0, 2);
    check("t5_req_len", last_run, 9);
    check("t5_err", timeout_err, 1);
    check("t5_mode", mode_select, m0);
    ack_en = 1'b1;
    press(0, 2);
    check("t5_err_sticky", timeout_err, 1);
    check("t5_mode_after", mode_select, exp_mode);

    // second press while in REQ is dropped
    dly = 3;
    exp_mode = model_step(exp_mode, 1'b1);
    exp_q.push_back(exp_mode);
    loads0 = loads;
    @(negedge clk);
    btn_next = 1'b1;
    cycles(2);
    btn_prev = 1'b1;
    cycles(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cycles(12);
    wait_idle("t6b");
    check("t6b_mode", mode_select, exp_mode);
    check("t6b_loads", loads - loads0, 1);

    // reset during REQ
    ack_en = 1'b0;
    @(negedge clk);
    btn_next = 1'b1;
    n = 0;
    while (!quiesce_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6c_req_rise", quiesce_req, 1);
    cycles(2);
    btn_next = 1'b0;
    reset_in = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6c");
    reset_in = 1'b0;
    exp_mode = 0;
    ack_en = 1'b1;
    cycles(12);
    press(0, 2);
    check("t6c_mode_after", mode_select, 1);

    cycles(5);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
